// File: rtl/game_controller.sv
// Game-loop sequencer for the memory game: menu, colour shuffle, two-card reveal,
// timed show window, match check, pair/move counting, end screen and restart.
module game_controller #(
  parameter int N_PAIRS     = 8,
  parameter int IDX_W       = 4,
  parameter int COLOR_W     = 4,
  parameter int SHOW_CYCLES = 65000000,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_butt_pressed,
  input  logic               abort_req,
  input  logic               compute_done,
  input  logic               card_pressed,
  input  logic [IDX_W-1:0]   card_idx,
  input  logic [COLOR_W-1:0] card_color,
  input  logic               card_matched,
  output logic               start_butt_en,
  output logic               compute_colors_en,
  output logic               update_cards_en,
  output logic               reveal_en,
  output logic [IDX_W-1:0]   reveal_idx,
  output logic [IDX_W-1:0]   first_idx,
  output logic [IDX_W-1:0]   second_idx,
  output logic               match_pulse,
  output logic               hide_pulse,
  output logic               end_screen_en,
  output logic [IDX_W-1:0]   pairs_found,
  output logic [CNT_W-1:0]   moves
);

  localparam int                SHOW_W    = $clog2(SHOW_CYCLES + 1);
  localparam logic [IDX_W:0]    N_CARDS   = (IDX_W + 1)'(2 * N_PAIRS);
  localparam logic [IDX_W-1:0]  PAIRS_ALL = IDX_W'(N_PAIRS);
  localparam logic [SHOW_W-1:0] SHOW_LOAD = SHOW_W'(SHOW_CYCLES - 1);

  typedef enum logic [3:0] {
    MAIN_MENU = 4'd0, COMPUTE, UPD1, WAIT1, DISC1, UPD2,
    WAIT2, DISC2, UPD3, SHOW, CHECK, ENDS
  } state_e;

  state_e              state, state_nxt;
  logic [COLOR_W-1:0]  color_a, color_b;
  logic [SHOW_W-1:0]   show_cnt;
  logic                abort_hit, click_ok, accept1, accept2, colors_eq, last_pair;
  logic                start_d, compute_d, update_d, reveal_d, match_d, hide_d, end_d;

  // Abort outranks everything, including a click that would otherwise be accepted.
  assign abort_hit = abort_req && (state != MAIN_MENU);
  assign click_ok  = card_pressed && ({1'b0, card_idx} < N_CARDS) && !card_matched;
  assign accept1   = (state == WAIT1) && click_ok && !abort_hit;
  assign accept2   = (state == WAIT2) && click_ok && (card_idx != first_idx) && !abort_hit;
  assign colors_eq = (color_a == color_b);
  assign last_pair = ((pairs_found + IDX_W'(1)) == PAIRS_ALL);

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MAIN_MENU;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    if (abort_hit) begin
      state_nxt = MAIN_MENU;
    end else begin
      case (state)
        MAIN_MENU: if (start_butt_pressed) state_nxt = COMPUTE;
        COMPUTE:   if (compute_done)       state_nxt = UPD1;
        UPD1:      state_nxt = WAIT1;
        WAIT1:     if (accept1)            state_nxt = DISC1;
        DISC1:     state_nxt = UPD2;
        UPD2:      state_nxt = WAIT2;
        WAIT2:     if (accept2)            state_nxt = DISC2;
        DISC2:     state_nxt = UPD3;
        UPD3:      state_nxt = SHOW;
        SHOW:      if (show_cnt == '0)     state_nxt = CHECK;
        CHECK:     state_nxt = (colors_eq && last_pair) ? ENDS : UPD1;
        ENDS:      if (start_butt_pressed) state_nxt = MAIN_MENU;
        default:   state_nxt = MAIN_MENU;
      endcase
    end
  end

  always_comb begin
    start_d   = (state == MAIN_MENU);
    compute_d = (state == COMPUTE);
    update_d  = (state == UPD1) || (state == UPD2) || (state == UPD3);
    reveal_d  = (state == DISC1) || (state == DISC2);
    end_d     = (state == ENDS);
    match_d   = (state == CHECK) && !abort_hit && colors_eq;
    hide_d    = (state == CHECK) && !abort_hit && !colors_eq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_butt_en     <= 1'b0;
      compute_colors_en <= 1'b0;
      update_cards_en   <= 1'b0;
      reveal_en         <= 1'b0;
      match_pulse       <= 1'b0;
      hide_pulse        <= 1'b0;
      end_screen_en     <= 1'b0;
    end else begin
      start_butt_en     <= start_d;
      compute_colors_en <= compute_d;
      update_cards_en   <= update_d;
      reveal_en         <= reveal_d;
      match_pulse       <= match_d;
      hide_pulse        <= hide_d;
      end_screen_en     <= end_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_idx   <= '0;
      second_idx  <= '0;
      reveal_idx  <= '0;
      color_a     <= '0;
      color_b     <= '0;
      show_cnt    <= '0;
      pairs_found <= '0;
      moves       <= '0;
    end else begin
      case (state)
        MAIN_MENU: begin
          pairs_found <= '0;
          moves       <= '0;
          first_idx   <= '0;
          second_idx  <= '0;
        end
        WAIT1: if (accept1) begin
          first_idx <= card_idx;
          color_a   <= card_color;
        end
        WAIT2: if (accept2) begin
          second_idx <= card_idx;
          color_b    <= card_color;
        end
        DISC1: reveal_idx <= first_idx;
        DISC2: reveal_idx <= second_idx;
        UPD3:  show_cnt   <= SHOW_LOAD;
        SHOW:  if (show_cnt != '0) show_cnt <= show_cnt - SHOW_W'(1);
        CHECK: if (!abort_hit) begin
          if (moves != {CNT_W{1'b1}}) moves <= moves + CNT_W'(1);
          if (colors_eq) pairs_found <= pairs_found + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: a turn-level game model checked every cycle,
// plus hand-computed literal checks at the key points of each scenario.
module tb_game_controller;

  localparam int N_PAIRS     = 2;
  localparam int IDX_W       = 4;
  localparam int COLOR_W     = 4;
  localparam int SHOW_CYCLES = 4;
  localparam int CNT_W       = 3;
  localparam int OUT_W       = 7 + 4 * IDX_W + CNT_W;

  logic               clk, rst_n;
  logic               start_butt_pressed, abort_req, compute_done, card_pressed, card_matched;
  logic [IDX_W-1:0]   card_idx;
  logic [COLOR_W-1:0] card_color;
  logic               start_butt_en, compute_colors_en, update_cards_en, reveal_en;
  logic [IDX_W-1:0]   reveal_idx, first_idx, second_idx, pairs_found;
  logic               match_pulse, hide_pulse, end_screen_en;
  logic [CNT_W-1:0]   moves;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_on     = 0;

  game_controller #(
    .N_PAIRS(N_PAIRS), .IDX_W(IDX_W), .COLOR_W(COLOR_W),
    .SHOW_CYCLES(SHOW_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_butt_pressed(start_butt_pressed), .abort_req(abort_req),
    .compute_done(compute_done), .card_pressed(card_pressed),
    .card_idx(card_idx), .card_color(card_color), .card_matched(card_matched),
    .start_butt_en(start_butt_en), .compute_colors_en(compute_colors_en),
    .update_cards_en(update_cards_en), .reveal_en(reveal_en),
    .reveal_idx(reveal_idx), .first_idx(first_idx), .second_idx(second_idx),
    .match_pulse(match_pulse), .hide_pulse(hide_pulse),
    .end_screen_en(end_screen_en), .pairs_found(pairs_found), .moves(moves)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Game model: phases describe what the player sees; k counts cards face-up this turn.
  typedef enum {M_MENU, M_SHUFFLE, M_REDRAW, M_PICK, M_FLIP, M_SHOWING, M_JUDGE, M_GAMEOVER} m_phase_e;
  m_phase_e           ph;
  int                 k, timer, m_pairs, m_moves;
  logic [IDX_W-1:0]   pick [2];
  logic [COLOR_W-1:0] pcol [2];
  logic               e_start, e_comp, e_upd, e_rev, e_match, e_hide, e_end;
  logic [IDX_W-1:0]   e_ridx;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      ph = M_MENU; k = 0; timer = 0; m_pairs = 0; m_moves = 0;
      pick[0] = '0; pick[1] = '0; pcol[0] = '0; pcol[1] = '0;
      e_start = 0; e_comp = 0; e_upd = 0; e_rev = 0; e_match = 0; e_hide = 0; e_end = 0;
      e_ridx = '0;
    end else begin
      // Enables appear one cycle after their phase is entered.
      e_start = (ph == M_MENU);
      e_comp  = (ph == M_SHUFFLE);
      e_upd   = (ph == M_REDRAW);
      e_rev   = (ph == M_FLIP);
      e_end   = (ph == M_GAMEOVER);
      e_match = 0;
      e_hide  = 0;
      if (ph == M_FLIP) e_ridx = pick[k-1];
      if (abort_req && ph != M_MENU) begin
        ph = M_MENU;
      end else begin
        case (ph)
          M_MENU: begin
            m_pairs = 0; m_moves = 0; pick[0] = '0; pick[1] = '0;
            if (start_butt_pressed) ph = M_SHUFFLE;
          end
          M_SHUFFLE: if (compute_done) begin k = 0; ph = M_REDRAW; end
          M_REDRAW: if (k == 2) begin timer = 0; ph = M_SHOWING; end else ph = M_PICK;
          M_PICK: if (card_pressed && int'(card_idx) < 2 * N_PAIRS && !card_matched &&
                      !(k == 1 && card_idx == pick[0])) begin
            pick[k] = card_idx; pcol[k] = card_color; k++; ph = M_FLIP;
          end
          M_FLIP: ph = M_REDRAW;
          M_SHOWING: begin timer++; if (timer == SHOW_CYCLES) ph = M_JUDGE; end
          M_JUDGE: begin
            if (m_moves < (1 << CNT_W) - 1) m_moves++;
            k = 0;
            if (pcol[0] == pcol[1]) begin
              e_match = 1; m_pairs++;
              ph = (m_pairs == N_PAIRS) ? M_GAMEOVER : M_REDRAW;
            end else begin
              e_hide = 1; ph = M_REDRAW;
            end
          end
          M_GAMEOVER: if (start_butt_pressed) ph = M_MENU;
          default: ph = M_MENU;
        endcase
      end
    end
  end

  initial forever begin
    logic [OUT_W-1:0] got, want;
    @(negedge clk);
    if (chk_on) begin
      got  = {start_butt_en, compute_colors_en, update_cards_en, reveal_en, reveal_idx,
              first_idx, second_idx, match_pulse, hide_pulse, end_screen_en, pairs_found, moves};
      want = {e_start, e_comp, e_upd, e_rev, e_ridx, pick[0], pick[1], e_match, e_hide,
              e_end, IDX_W'(m_pairs), CNT_W'(m_moves)};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL outputs t=%0t got=%h want=%h", $time, got, want);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      start_butt_pressed = 0; abort_req = 0; compute_done = 0;
      card_pressed = 0; card_matched = 0;
    end
  endtask

  task automatic click(input int idx, input int col, input bit matched);
    card_pressed = 1; card_idx = IDX_W'(idx); card_color = COLOR_W'(col); card_matched = matched;
    cyc();
  endtask

  // From the menu to WAIT1 with the redraw pulse already gone.
  task automatic start_game();
    start_butt_pressed = 1; cyc();
    compute_done = 1; cyc();
    cyc(2);
  endtask

  // WAIT1 -> WAIT2.
  task automatic first_half(input int idx, input int col);
    click(idx, col, 0); cyc(2);
  endtask

  // WAIT2 -> the cycle on which match_pulse/hide_pulse is visible.
  task automatic second_half(input int idx, input int col);
    click(idx, col, 0); cyc(2 + SHOW_CYCLES + 1);
  endtask

  initial begin
    rst_n = 1; start_butt_pressed = 0; abort_req = 0; compute_done = 0;
    card_pressed = 0; card_matched = 0; card_idx = '0; card_color = '0;
    #2 rst_n = 0; chk_on = 1;
    #1 check("reset_start_en", start_butt_en, 0);
    check("reset_moves", moves, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cyc();
    check("menu_start_en", start_butt_en, 1);

    // Start, shuffle, first redraw.
    start_butt_pressed = 1; cyc();
    compute_done = 1; cyc();
    check("compute_en", compute_colors_en, 1);
    cyc();
    check("upd1_pulse", update_cards_en, 1);
    cyc();
    check("upd1_pulse_gone", update_cards_en, 0);

    // Matching turn: idx 1 and 2, both colour 3.
    click(1, 3, 0); cyc();
    check("reveal1_en", reveal_en, 1);
    check("reveal1_idx", reveal_idx, 1);
    cyc();
    click(2, 3, 0); cyc();
    check("reveal2_en", reveal_en, 1);
    check("reveal2_idx", reveal_idx, 2);
    cyc(1 + SHOW_CYCLES);
    check("no_match_during_check", match_pulse, 0);
    cyc();
    check("match_pulse", match_pulse, 1);
    check("pairs_after_match", pairs_found, 1);
    check("moves_after_match", moves, 1);
    check("model_pairs_pin", m_pairs, 1);
    cyc();

    // Mismatching turn: idx 0 colour 5, idx 3 colour 6.
    first_half(0, 5);
    second_half(3, 6);
    check("hide_pulse", hide_pulse, 1);
    check("hide_first", first_idx, 0);
    check("hide_second", second_idx, 3);
    check("pairs_unchanged", pairs_found, 1);
    check("moves_after_hide", moves, 2);
    cyc();

    // Rejected second clicks: same card, matched card, out of range.
    first_half(0, 5);
    click(0, 5, 0);
    click(1, 3, 1);
    click(5, 5, 0);
    cyc();
    check("rejects_no_reveal", reveal_en, 0);
    check("rejects_second_held", second_idx, 3);
    click(3, 5, 0); cyc();
    check("accept_after_reject", reveal_idx, 3);
    cyc(1 + SHOW_CYCLES + 1);
    check("final_match", match_pulse, 1);
    check("final_pairs", pairs_found, 2);
    cyc();
    check("end_screen", end_screen_en, 1);
    check("end_moves", moves, 3);
    start_butt_pressed = 1; cyc();
    cyc();
    check("restart_menu", start_butt_en, 1);
    check("restart_pairs", pairs_found, 0);
    check("restart_moves", moves, 0);

    // Abort in the middle of the show window.
    start_game();
    first_half(1, 7);
    click(2, 7, 0); cyc(3);
    abort_req = 1; cyc();
    check("abort_no_match", match_pulse, 0);
    check("abort_no_hide", hide_pulse, 0);
    cyc();
    check("abort_menu", start_butt_en, 1);
    cyc(SHOW_CYCLES + 2);
    check("abort_moves", moves, 0);

    // Eight mismatches: moves saturates at 7.
    start_game();
    for (int j = 0; j < 8; j++) begin
      first_half(0, 1);
      second_half(1, 2);
      check("sat_hide", hide_pulse, 1);
      check("sat_moves", moves, (j + 1 > 7) ? 7 : j + 1);
      cyc();
    end
    check("sat_pairs", pairs_found, 0);

    // Asynchronous reset in WAIT2.
    first_half(2, 4);
    check("pre_reset_first", first_idx, 2);
    #2 rst_n = 0;
    #1 check("async_first", first_idx, 0);
    check("async_moves", moves, 0);
    check("async_start_en", start_butt_en, 0);
    @(posedge clk); #1 rst_n = 1;
    cyc();
    check("post_reset_menu", start_butt_en, 1);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
